// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: Wishbone classic-cycle bus between the command master and a register slave.
interface wb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_we_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic                  wb_ack_i;
  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );
  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: queued command stream to Wishbone classic single cycles with buffered responses,
// ack timeout reporting and interrupt rising-edge detection.
module wb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [DATA_WIDTH-1:0] cmd_dat,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dat,
  output logic                  rsp_we,
  output logic                  rsp_err,
  wb_cmd_master_if.master       wb,
  input  logic                  int_i,
  output logic                  irq_rise_o,
  output logic                  busy_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH;
  localparam int RW = DATA_WIDTH + 2;
  typedef enum logic {IDLE, BUS} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cmd_mem [FIFO_DEPTH];
  logic [RW-1:0] r_rsp_mem [FIFO_DEPTH];
  logic [PW:0] r_cmd_wp, r_cmd_rp, r_rsp_wp, r_rsp_rp;
  logic [15:0] r_cnt;
  logic r_int_q, r_irq;
  logic w_cmd_full, w_cmd_empty, w_rsp_full, w_cmd_push, w_rsp_pop, w_start, w_done;
  logic [RW-1:0] w_rsp_in;
  assign w_cmd_empty = r_cmd_wp == r_cmd_rp;
  assign w_cmd_full  = r_cmd_wp == {~r_cmd_rp[PW], r_cmd_rp[PW-1:0]};
  assign w_rsp_full  = r_rsp_wp == {~r_rsp_rp[PW], r_rsp_rp[PW-1:0]};
  assign cmd_ready   = !w_cmd_full;
  assign rsp_valid   = r_rsp_wp != r_rsp_rp;
  assign {rsp_dat, rsp_we, rsp_err} = r_rsp_mem[r_rsp_rp[PW-1:0]];
  assign w_cmd_push  = cmd_valid && !w_cmd_full;
  assign w_rsp_pop   = rsp_valid && rsp_ready;
  assign busy_o      = r_state != IDLE || !w_cmd_empty;
  assign irq_rise_o  = r_irq;
  // Starting only with response space free means a finished transaction can always be recorded.
  always_comb begin
    w_start   = r_state == IDLE && !w_cmd_empty && !w_rsp_full;
    w_done    = r_state == BUS && (wb.wb_ack_i || r_cnt == 16'(TIMEOUT - 1));
    w_rsp_in  = wb.wb_ack_i ? {wb.wb_we_o ? {DATA_WIDTH{1'b0}} : wb.wb_dat_i, wb.wb_we_o, 1'b0}
                            : {{DATA_WIDTH{1'b0}}, wb.wb_we_o, 1'b1};
    w_state_n = w_start ? BUS : w_done ? IDLE : r_state;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_wp    <= '0;
      r_cmd_rp    <= '0;
      r_rsp_wp    <= '0;
      r_rsp_rp    <= '0;
      r_cnt       <= '0;
      r_int_q     <= 1'b0;
      r_irq       <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
    end else begin
      r_state     <= w_state_n;
      r_int_q     <= int_i;
      r_irq       <= int_i && !r_int_q;
      wb.wb_cyc_o <= w_state_n == BUS;
      wb.wb_stb_o <= w_state_n == BUS;
      if (w_cmd_push) begin
        r_cmd_mem[r_cmd_wp[PW-1:0]] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        r_cmd_wp <= r_cmd_wp + 1'b1;
      end
      if (w_start) begin
        {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o} <= r_cmd_mem[r_cmd_rp[PW-1:0]];
        r_cmd_rp <= r_cmd_rp + 1'b1;
        r_cnt    <= '0;
      end else if (r_state == BUS) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_rsp_mem[r_rsp_wp[PW-1:0]] <= w_rsp_in;
        r_rsp_wp <= r_rsp_wp + 1'b1;
      end
      if (w_rsp_pop) r_rsp_rp <= r_rsp_rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed stimulus with a response scoreboard and a Wishbone slave responder.
module tb_wb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 4;
  localparam int TO = 8;
  typedef struct packed {logic [DW-1:0] dat; logic we; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic rsp_ready = 1'b0;
  logic int_i = 1'b0;
  logic cmd_ready, rsp_valid, rsp_we, rsp_err, irq_rise, busy;
  logic [DW-1:0] rsp_dat;
  logic force_ack = 1'b0;
  logic we_any = 1'b0;
  logic last_we = 1'b0;
  logic [DW-1:0] mem [32];
  exp_t sb [$];
  int errors = 0;
  int checks = 0;
  int slave_delay = 1;
  int scnt = 0;
  int run = 0;
  int last_len = 0;
  int irq_cnt = 0;
  always #5 clk = ~clk;
  wb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();
  wb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_we(rsp_we), .rsp_err(rsp_err),
    .wb(wb.master),
    .int_i(int_i), .irq_rise_o(irq_rise), .busy_o(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic err, input bit track);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_sel = sel;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    if (track) sb.push_back('{dat: (we || err) ? '0 : mem[adr], we: we, err: err});
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((sb.size() != 0 || busy || rsp_valid) && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(n < 300), 32'd1);
  endtask
  // Slave: acks once stb has been seen slave_delay times; a negative delay never acks.
  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    forever begin
      tick();
      if (force_ack) wb.wb_ack_i = 1'b1;
      else if (wb.wb_stb_o && !wb.wb_ack_i) begin
        wb.wb_ack_i = scnt == slave_delay;
        wb.wb_dat_i = mem[wb.wb_adr_o];
        scnt++;
      end else begin
        wb.wb_ack_i = 1'b0;
        scnt = 0;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("rsp_dat", rsp_dat, e.dat);
          check("rsp_we", 32'(rsp_we), 32'(e.we));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (wb.wb_stb_o) begin
        run++;
        we_any = we_any | wb.wb_we_o;
      end else if (run != 0) begin
        last_len = run;
        last_we = we_any;
        run = 0;
        we_any = 1'b0;
      end
      if (irq_rise === 1'b1) irq_cnt++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | (i * 32'h1111);
    mem[5] = 32'h60;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_cyc", 32'(wb.wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb.wb_stb_o), 32'd0);
    check("rst_we", 32'(wb.wb_we_o), 32'd0);
    check("rst_adr", 32'(wb.wb_adr_o), 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb.wb_sel_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_irq", 32'(irq_rise), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    slave_delay = 2;
    send(1'b1, 5'd3, 32'h83, 4'h1, 1'b0, 1'b1);
    check("wr_cyc_latency", 32'(wb.wb_cyc_o), 32'd0);
    tick();
    check("wr_cyc", 32'(wb.wb_cyc_o), 32'd1);
    check("wr_stb", 32'(wb.wb_stb_o), 32'd1);
    check("wr_adr", 32'(wb.wb_adr_o), 32'd3);
    check("wr_dat", wb.wb_dat_o, 32'h83);
    check("wr_sel", 32'(wb.wb_sel_o), 32'h1);
    check("wr_we", 32'(wb.wb_we_o), 32'd1);
    wait_idle();
    check("wr_stb_len", last_len, 32'd3);
    check("idle_adr_hold", 32'(wb.wb_adr_o), 32'd3);
    check("idle_dat_hold", wb.wb_dat_o, 32'h83);
    slave_delay = 1;
    send(1'b0, 5'd5, 32'hDEAD, 4'hF, 1'b0, 1'b1);
    wait_idle();
    check("rd_we_low", 32'(last_we), 32'd0);
    check("rd_stb_len", last_len, 32'd2);
    slave_delay = -1;
    send(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, 1'b1);
    wait_idle();
    check("timeout_stb_len", last_len, 32'd8);
    slave_delay = 7;
    send(1'b0, 5'd7, 32'h0, 4'hF, 1'b0, 1'b1);
    wait_idle();
    check("ack_last_cycle_len", last_len, 32'd8);
    rsp_ready = 1'b0;
    slave_delay = -1;
    send(1'b0, 5'd9, 32'h0, 4'hF, 1'b1, 1'b1);
    send(1'b1, 5'd1, 32'h11, 4'h3, 1'b0, 1'b1);
    send(1'b0, 5'd2, 32'h0, 4'hF, 1'b0, 1'b1);
    send(1'b0, 5'd4, 32'h0, 4'hF, 1'b0, 1'b1);
    send(1'b1, 5'd6, 32'h66, 4'hC, 1'b0, 1'b1);
    check("bp_cmd_full", 32'(cmd_ready), 32'd0);
    slave_delay = 1;
    send(1'b0, 5'd8, 32'h0, 4'hF, 1'b0, 1'b1);
    repeat (40) tick();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    repeat (10) begin
      tick();
      if (wb.wb_cyc_o) c++;
    end
    check("bp_no_cyc", c, 32'd0);
    rsp_ready = 1'b1;
    wait_idle();
    slave_delay = -1;
    send(1'b1, 5'd2, 32'h22, 4'hF, 1'b0, 1'b0);
    send(1'b1, 5'd4, 32'h44, 4'hF, 1'b0, 1'b0);
    tick();
    check("mid_bus_stb", 32'(wb.wb_stb_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cyc", 32'(wb.wb_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wb.wb_stb_o), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    force_ack = 1'b1;
    repeat (2) tick();
    force_ack = 1'b0;
    tick();
    check("late_ack_cyc", 32'(wb.wb_cyc_o), 32'd0);
    check("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    int_i = 1'b1;
    tick();
    check("irq_first_pulse", 32'(irq_rise), 32'd1);
    tick();
    check("irq_first_end", 32'(irq_rise), 32'd0);
    repeat (3) tick();
    int_i = 1'b0;
    repeat (3) tick();
    check("irq_fall_quiet", 32'(irq_rise), 32'd0);
    int_i = 1'b1;
    tick();
    check("irq_second_pulse", 32'(irq_rise), 32'd1);
    tick();
    check("irq_second_end", 32'(irq_rise), 32'd0);
    repeat (3) tick();
    check("irq_count", irq_cnt, 32'd2);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
